sdram_command_responder: RTL and testbench

Responder end of the state-controller SDRAM command interface (`sdram_inputAddress`/`sdram_writeData`/`sdram_isWriting`/`sdram_inputValid` in; `sdram_readData`/`sdram_outputValid`/`sdram_recievedCommand`/`sdram_isBusy` out). It accepts one command at a time from the state-controller mux and executes it as a single Avalon-MM transfer on the SDRAM controller IP. Read data returns with a one-cycle valid pulse. A timeout guard stops a stalled SDRAM controller from hanging the recording states.

---
 rtl/sdram_command_responder.sv | 177 +++++++++++++++++
 tb/tb_sdram_command_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_command_responder.sv
// sdram_command_responder
// Takes one command at a time from the state-controller mux and runs it as a
// single Avalon-MM transfer on the SDRAM controller. A cycle counter aborts
// transfers that stall too long, so the recording states never hang.
//
// Ports:
//   clock_50Mhz, reset_n        clock, synchronous active-low reset
//   sdram_inputAddress/WriteData/isWriting/inputValid   command request in
//   sdram_readData/outputValid  read result + one-cycle valid pulse
//   sdram_recievedCommand       one-cycle capture acknowledge
//   sdram_isBusy                high from capture until back in IDLE
//   avm_*                       Avalon-MM host side
//   timeout_error               sticky abort flag, cleared only by reset
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for sdram_inputValid
// ISSUE     | avm_read/avm_write held until waitrequest drops
// READ_WAIT | read accepted, waiting for avm_readdatavalid
// RELEASE   | one trailing busy cycle before returning to IDLE
module sdram_command_responder #(
   parameter int ADDR_W         = 25,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clock_50Mhz,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   sdram_inputAddress,
   input  logic [DATA_W-1:0]   sdram_writeData,
   input  logic                sdram_isWriting,
   input  logic                sdram_inputValid,
   output logic [DATA_W-1:0]   sdram_readData,
   output logic                sdram_outputValid,
   output logic                sdram_recievedCommand,
   output logic                sdram_isBusy,
   output logic [ADDR_W-1:0]   avm_address,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic                avm_read,
   output logic                avm_write,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid,
   input  logic                avm_waitrequest,
   output logic                timeout_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_READ_WAIT = 2'd2,
      ST_RELEASE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              terr_q, terr_d;

   // A read is only complete once its data returns; acceptance alone is not
   // completion, so a read accepted on the timeout edge is still aborted.
   logic xfer_done;
   logic timeout_hit;

   assign xfer_done   = ((state_q == ST_ISSUE) && is_wr_q && !avm_waitrequest) ||
                        ((state_q == ST_READ_WAIT) && avm_readdatavalid);
   assign timeout_hit = ((state_q == ST_ISSUE) || (state_q == ST_READ_WAIT)) &&
                        (cnt_q == CNT_LAST) && !xfer_done;

   always_ff @(posedge clock_50Mhz) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         is_wr_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_wr_q  <= is_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         terr_q   <= terr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (sdram_inputValid) state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (timeout_hit)           state_d = ST_RELEASE;
            else if (!avm_waitrequest) state_d = is_wr_q ? ST_RELEASE : ST_READ_WAIT;
         end
         ST_READ_WAIT: if (xfer_done || timeout_hit) state_d = ST_RELEASE;
         ST_RELEASE:   state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      ack_d    = 1'b0;
      terr_d   = terr_q;

      if ((state_q == ST_IDLE) && sdram_inputValid) begin
         is_wr_d = sdram_isWriting;
         addr_d  = sdram_inputAddress;
         wdata_d = sdram_writeData;
         cnt_d   = '0;
         ack_d   = 1'b1;
      end

      if (((state_q == ST_ISSUE) || (state_q == ST_READ_WAIT)) && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;

      if ((state_q == ST_READ_WAIT) && avm_readdatavalid) begin
         rdata_d  = avm_readdata;
         rvalid_d = 1'b1;
      end

      // Aborted reads still produce a (zero) result so the initiator unblocks.
      if (timeout_hit) begin
         terr_d = 1'b1;
         if (!is_wr_q) begin
            rdata_d  = '0;
            rvalid_d = 1'b1;
         end
      end

      // Request lines and busy follow the state being entered, keeping every
      // output registered.
      busy_d = (state_d != ST_IDLE);
      rd_d   = (state_d == ST_ISSUE) && !is_wr_d;
      wr_d   = (state_d == ST_ISSUE) && is_wr_d;
   end

   assign sdram_readData        = rdata_q;
   assign sdram_outputValid     = rvalid_q;
   assign sdram_recievedCommand = ack_q;
   assign sdram_isBusy          = busy_q;
   assign avm_address           = addr_q;
   assign avm_writedata         = wdata_q;
   assign avm_byteenable        = '1;
   assign avm_read              = rd_q;
   assign avm_write             = wr_q;
   assign timeout_error         = terr_q;

endmodule

// File: tb/tb_sdram_command_responder.sv
module tb_sdram_command_responder;

   localparam int T = 8;

   logic        clk;
   logic        rst_n;
   logic [24:0] in_addr;
   logic [15:0] in_wdata;
   logic        in_is_wr;
   logic        in_valid;
   logic [15:0] rd_data;
   logic        out_valid;
   logic        ack;
   logic        busy;
   logic [24:0] avm_address;
   logic [15:0] avm_writedata;
   logic [1:0]  avm_byteenable;
   logic        avm_read;
   logic        avm_write;
   logic [15:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        avm_waitrequest;
   logic        timeout_error;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] rdata_m = '0;
   bit          terr_m  = 0;

   sdram_command_responder #(
      .ADDR_W(25), .DATA_W(16), .TIMEOUT_CYCLES(T)
   ) dut (
      .clock_50Mhz           (clk),
      .reset_n               (rst_n),
      .sdram_inputAddress    (in_addr),
      .sdram_writeData       (in_wdata),
      .sdram_isWriting       (in_is_wr),
      .sdram_inputValid      (in_valid),
      .sdram_readData        (rd_data),
      .sdram_outputValid     (out_valid),
      .sdram_recievedCommand (ack),
      .sdram_isBusy          (busy),
      .avm_address           (avm_address),
      .avm_writedata         (avm_writedata),
      .avm_byteenable        (avm_byteenable),
      .avm_read              (avm_read),
      .avm_write             (avm_write),
      .avm_readdata          (avm_readdata),
      .avm_readdatavalid     (avm_readdatavalid),
      .avm_waitrequest       (avm_waitrequest),
      .timeout_error         (timeout_error)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: with w stall cycles the transfer is accepted at edge a = w+1
   // after capture (E0); read data arrives lat edges later. The timeout fires
   // at edge T unless the transfer completes at or before it.
   task automatic run_cmd(input bit wr, input logic [24:0] ad, input logic [15:0] wd,
                          input int w, input int lat, input logic [15:0] rd,
                          input bit hold, input bit spur);
      int a, end_e, req_exp, k;
      bit done, finished;
      int n_req, n_other, n_ack, n_busy, n_ov, n_bad;
      bit ack0;
      logic [15:0] ov_d;

      a = w + 1;
      if (wr) done = (a <= T);
      else    done = (a < T) && (a + lat <= T);
      end_e   = done ? (wr ? a : a + lat) : T;
      req_exp = (a < T) ? a : T;

      n_req = 0; n_other = 0; n_ack = 0; n_busy = 0; n_ov = 0; n_bad = 0;
      ack0 = 0; ov_d = '0; finished = 0;

      in_valid = 1'b1; in_is_wr = wr; in_addr = ad; in_wdata = wd;
      avm_waitrequest = 1'b1; avm_readdatavalid = spur;

      for (int j = 0; j < 60 && !finished; j++) begin
         @(posedge clk);
         @(negedge clk);
         if (j > 0 && !busy) finished = 1;
         else begin
            if (wr ? avm_write : avm_read) begin
               n_req++;
               if (avm_address !== ad) n_bad++;
               if (wr && avm_writedata !== wd) n_bad++;
            end
            if (wr ? avm_read : avm_write) n_other++;
            if (ack) begin
               n_ack++;
               if (j == 0) ack0 = 1;
            end
            if (busy) n_busy++;
            if (out_valid) begin
               n_ov++;
               ov_d = rd_data;
            end
            k = j + 1;
            if (!hold) in_valid = 1'b0;
            in_addr  = 25'($urandom);
            in_wdata = 16'($urandom);
            in_is_wr = 1'($urandom);
            avm_waitrequest   = (k <= w);
            avm_readdatavalid = (!wr && k == a + lat) || (spur && k <= a);
            avm_readdata      = (!wr && k == a + lat) ? rd : 16'($urandom);
         end
      end
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;

      chk("finished_in_budget", 32'(finished), 1);
      chk("req_cycles", n_req, req_exp);
      chk("other_req", n_other, 0);
      chk("addr_data_on_bus", n_bad, 0);
      chk("ack_count", n_ack, 1);
      chk("ack_after_e0", 32'(ack0), 1);
      chk("busy_cycles", n_busy, end_e + 1);
      chk("out_valid_count", n_ov, wr ? 0 : 1);
      if (!wr) begin
         rdata_m = done ? rd : 16'h0;
         chk("out_valid_data", 32'(ov_d), 32'(rdata_m));
      end
      if (!done) terr_m = 1;
      chk("read_data_hold", 32'(rd_data), 32'(rdata_m));
      chk("timeout_error", 32'(timeout_error), 32'(terr_m));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_is_wr = 1'b0; in_addr = '0; in_wdata = '0;
      avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_read_data", 32'(rd_data), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_avm_address", 32'(avm_address), 0);
      chk("rst_avm_writedata", 32'(avm_writedata), 0);
      chk("rst_byteenable", 32'(avm_byteenable), 32'h3);
      chk("rst_avm_read", 32'(avm_read), 0);
      chk("rst_avm_write", 32'(avm_write), 0);
      chk("rst_timeout_error", 32'(timeout_error), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero-wait write
      run_cmd(1, 25'h0000123, 16'hBEEF, 0, 1, 16'h0, 0, 0);
      // Stalled read; data lands exactly on the timeout edge, completion wins
      run_cmd(0, 25'h1FFFFFF, 16'h0, 3, 4, 16'hA5A5, 0, 0);
      // Read stalled forever by waitrequest
      run_cmd(0, 25'h0000456, 16'h0, 100, 1, 16'h1234, 0, 0);
      // Following write completes normally, error stays sticky
      run_cmd(1, 25'h0000789, 16'hCAFE, 1, 1, 16'h0, 0, 0);
      // Read accepted but data never returns
      run_cmd(0, 25'h00000AA, 16'h0, 0, 100, 16'h7777, 0, 1);
      // Held inputValid: next command captured on the first IDLE edge
      run_cmd(1, 25'h0ABCDEF, 16'h1357, 0, 1, 16'h0, 1, 0);
      run_cmd(0, 25'h0012345, 16'h0, 1, 2, 16'h2468, 0, 1);

      for (int i = 0; i < 24; i++)
         run_cmd(1'($urandom), 25'($urandom), 16'($urandom), $urandom_range(0, 9),
                 $urandom_range(1, 9), 16'($urandom), 1'($urandom), 1'($urandom));

      // Reset in READ_WAIT, then a late readdatavalid
      in_valid = 1'b1; in_is_wr = 1'b0; in_addr = 25'h0000321;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("midrst_in_read_wait", 32'(busy & ~avm_read), 1);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_avm_read", 32'(avm_read), 0);
      rst_n = 1'b1;
      avm_readdatavalid = 1'b1;
      avm_readdata = 16'h5A5A;
      rdata_m = '0;
      terr_m = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         avm_readdatavalid = 1'b0;
         chk("midrst_out_valid", 32'(out_valid), 0);
         chk("midrst_read_data", 32'(rd_data), 32'(rdata_m));
         chk("midrst_busy_after", 32'(busy), 0);
      end
      chk("midrst_timeout_error", 32'(timeout_error), 32'(terr_m));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
